// File: rtl/exu_decode_pipe.sv
// RV32IM decode stage: a DEPTH-entry instruction queue feeding a registered
// decoder, with valid/ready handshakes on both sides and a pipeline flush.
module exu_decode_pipe #(
    parameter int XLEN     = 32,
    parameter int PC_SIZE  = 32,
    parameter int DEPTH    = 4,
    parameter int ENABLE_M = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_valid,
    output logic                     i_ready,
    input  logic [31:0]              i_instr,
    input  logic [PC_SIZE-1:0]       i_pc,
    input  logic                     i_prdt_taken,
    input  logic                     flush,
    output logic                     o_valid,
    input  logic                     o_ready,
    output logic                     o_rs1en,
    output logic                     o_rs2en,
    output logic                     o_rdwen,
    output logic [4:0]               o_rs1idx,
    output logic [4:0]               o_rs2idx,
    output logic [4:0]               o_rdidx,
    output logic [XLEN-1:0]          o_imm,
    output logic [PC_SIZE-1:0]       o_pc,
    output logic                     o_prdt_taken,
    output logic [2:0]               o_grp,
    output logic                     o_bjp,
    output logic                     o_jal,
    output logic                     o_jalr,
    output logic                     o_bxx,
    output logic                     o_illegal,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        GRP_ALU    = 3'd0,
        GRP_BJP    = 3'd1,
        GRP_AGU    = 3'd2,
        GRP_MULDIV = 3'd3,
        GRP_ILL    = 3'd7
    } grp_e;

    typedef struct packed {
        logic            rs1en;
        logic            rs2en;
        logic            rdwen;
        logic [4:0]      rs1idx;
        logic [4:0]      rs2idx;
        logic [4:0]      rdidx;
        logic [XLEN-1:0] imm;
        grp_e            grp;
        logic            jal;
        logic            jalr;
        logic            bxx;
        logic            illegal;
    } dec_t;

    // ------------------------------------------------------------------
    // Instruction queue
    // ------------------------------------------------------------------
    logic [31:0]        instr_mem [DEPTH];
    logic [PC_SIZE-1:0] pc_mem    [DEPTH];
    logic               prdt_mem  [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic full, empty, push, load;
    logic valid_q;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign i_ready = !full && !rst && !flush;
    assign push    = i_valid && i_ready;
    // Pop and output-register load are the same event; flush and reset win.
    assign load    = !empty && (!valid_q || o_ready) && !rst && !flush;

    always_ff @(posedge clk) begin
        // NOTE: queue storage has no reset; the pointers and count do, so a
        // stale slot is never presented as a valid entry.
        if (push) begin
            instr_mem[wr_ptr_q] <= i_instr;
            pc_mem[wr_ptr_q]    <= i_pc;
            prdt_mem[wr_ptr_q]  <= i_prdt_taken;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (load) rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(push) - CW'(load);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous; rst only takes effect on a rising edge.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // ------------------------------------------------------------------
    // Decode of the queue head
    // ------------------------------------------------------------------
    logic [31:0] ins;
    logic [6:0]  opcode;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign ins    = instr_mem[rd_ptr_q];
    assign opcode = ins[6:0];
    assign funct3 = ins[14:12];
    assign funct7 = ins[31:25];

    assign imm_i = {{20{ins[31]}}, ins[31:20]};
    assign imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    assign imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    assign imm_u = {ins[31:12], 12'b0};
    assign imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};

    logic        legal;
    grp_e        grp;
    logic        rs1en, rs2en, rdwen, jal, jalr, bxx;
    logic [31:0] imm32;
    dec_t        dec_d, dec_q;

    always_comb begin
        legal = 1'b0;
        grp   = GRP_ALU;
        rs1en = 1'b0;
        rs2en = 1'b0;
        rdwen = 1'b0;
        jal   = 1'b0;
        jalr  = 1'b0;
        bxx   = 1'b0;
        imm32 = '0;
        case (opcode)
            OPC_LUI, OPC_AUIPC: begin
                legal = 1'b1;
                rdwen = 1'b1;
                imm32 = imm_u;
            end
            OPC_JAL: begin
                legal = 1'b1;
                grp   = GRP_BJP;
                jal   = 1'b1;
                rdwen = 1'b1;
                imm32 = imm_j;
            end
            OPC_JALR: begin
                legal = (funct3 == 3'b000);
                grp   = GRP_BJP;
                jalr  = 1'b1;
                rs1en = 1'b1;
                rdwen = 1'b1;
                imm32 = imm_i;
            end
            OPC_BRANCH: begin
                legal = !(funct3 inside {3'b010, 3'b011});
                grp   = GRP_BJP;
                bxx   = 1'b1;
                rs1en = 1'b1;
                rs2en = 1'b1;
                imm32 = imm_b;
            end
            OPC_LOAD: begin
                legal = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
                grp   = GRP_AGU;
                rs1en = 1'b1;
                rdwen = 1'b1;
                imm32 = imm_i;
            end
            OPC_STORE: begin
                legal = funct3 inside {3'b000, 3'b001, 3'b010};
                grp   = GRP_AGU;
                rs1en = 1'b1;
                rs2en = 1'b1;
                imm32 = imm_s;
            end
            OPC_OPIMM: begin
                // Shift-immediates reuse imm[11:5] as a function qualifier.
                case (funct3)
                    3'b001:  legal = (funct7 == 7'b0000000);
                    3'b101:  legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                    default: legal = 1'b1;
                endcase
                rs1en = 1'b1;
                rdwen = 1'b1;
                imm32 = imm_i;
            end
            OPC_OP: begin
                rs1en = 1'b1;
                rs2en = 1'b1;
                rdwen = 1'b1;
                if (funct7 == 7'b0000000) begin
                    legal = 1'b1;
                end else if (funct7 == 7'b0100000) begin
                    legal = (funct3 == 3'b000) || (funct3 == 3'b101);
                end else if ((funct7 == 7'b0000001) && (ENABLE_M != 0)) begin
                    legal = 1'b1;
                    grp   = GRP_MULDIV;
                end
            end
            default: legal = 1'b0;
        endcase

        dec_d        = '0;
        dec_d.rs1idx = ins[19:15];
        dec_d.rs2idx = ins[24:20];
        dec_d.rdidx  = ins[11:7];
        if (legal) begin
            dec_d.rs1en = rs1en;
            dec_d.rs2en = rs2en;
            dec_d.rdwen = rdwen && (ins[11:7] != 5'd0);
            dec_d.imm   = XLEN'(signed'(imm32));
            dec_d.grp   = grp;
            dec_d.jal   = jal;
            dec_d.jalr  = jalr;
            dec_d.bxx   = bxx;
        end else begin
            dec_d.illegal = 1'b1;
            dec_d.grp     = GRP_ILL;
        end
    end

    // ------------------------------------------------------------------
    // Output register: holds while o_valid && !o_ready
    // ------------------------------------------------------------------
    logic [PC_SIZE-1:0] pc_q;
    logic               prdt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            dec_q   <= '0;
            pc_q    <= '0;
            prdt_q  <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (load) begin
            valid_q <= 1'b1;
            dec_q   <= dec_d;
            pc_q    <= pc_mem[rd_ptr_q];
            prdt_q  <= prdt_mem[rd_ptr_q];
        end else if (o_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign o_valid      = valid_q;
    assign o_rs1en      = dec_q.rs1en;
    assign o_rs2en      = dec_q.rs2en;
    assign o_rdwen      = dec_q.rdwen;
    assign o_rs1idx     = dec_q.rs1idx;
    assign o_rs2idx     = dec_q.rs2idx;
    assign o_rdidx      = dec_q.rdidx;
    assign o_imm        = dec_q.imm;
    assign o_pc         = pc_q;
    assign o_prdt_taken = prdt_q;
    assign o_grp        = dec_q.grp;
    assign o_jal        = dec_q.jal;
    assign o_jalr       = dec_q.jalr;
    assign o_bxx        = dec_q.bxx;
    assign o_bjp        = dec_q.jal | dec_q.jalr | dec_q.bxx;
    assign o_illegal    = dec_q.illegal;
    assign o_count      = count_q;

endmodule

// File: tb/tb_exu_decode_pipe.sv
// Bench for exu_decode_pipe: directed scenarios then random traffic, checked
// every cycle against a queue-based reference model (with and without M).
module tb_exu_decode_pipe;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush, i_valid, o_ready, i_prdt_taken;
    logic [31:0] i_instr, i_pc;

    typedef struct packed {
        logic        valid;
        logic [2:0]  count;
        logic        rs1en;
        logic        rs2en;
        logic        rdwen;
        logic [4:0]  rs1idx;
        logic [4:0]  rs2idx;
        logic [4:0]  rdidx;
        logic [31:0] imm;
        logic [31:0] pc;
        logic        prdt;
        logic [2:0]  grp;
        logic        bjp;
        logic        jal;
        logic        jalr;
        logic        bxx;
        logic        illegal;
    } obs_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        prdt;
    } ent_t;

    // DUT with M extension (m_*) and without (n_*), driven identically
    logic        m_i_ready, m_valid, m_rs1en, m_rs2en, m_rdwen, m_prdt;
    logic [4:0]  m_rs1idx, m_rs2idx, m_rdidx;
    logic [31:0] m_imm, m_pc;
    logic [2:0]  m_grp, m_count;
    logic        m_bjp, m_jal, m_jalr, m_bxx, m_illegal;
    logic        n_i_ready, n_valid, n_rs1en, n_rs2en, n_rdwen, n_prdt;
    logic [4:0]  n_rs1idx, n_rs2idx, n_rdidx;
    logic [31:0] n_imm, n_pc;
    logic [2:0]  n_grp, n_count;
    logic        n_bjp, n_jal, n_jalr, n_bxx, n_illegal;

    exu_decode_pipe #(.XLEN(32), .PC_SIZE(32), .DEPTH(DEPTH), .ENABLE_M(1)) dut_m (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(m_i_ready),
        .i_instr(i_instr), .i_pc(i_pc), .i_prdt_taken(i_prdt_taken), .flush(flush),
        .o_valid(m_valid), .o_ready(o_ready),
        .o_rs1en(m_rs1en), .o_rs2en(m_rs2en), .o_rdwen(m_rdwen),
        .o_rs1idx(m_rs1idx), .o_rs2idx(m_rs2idx), .o_rdidx(m_rdidx),
        .o_imm(m_imm), .o_pc(m_pc), .o_prdt_taken(m_prdt), .o_grp(m_grp),
        .o_bjp(m_bjp), .o_jal(m_jal), .o_jalr(m_jalr), .o_bxx(m_bxx),
        .o_illegal(m_illegal), .o_count(m_count)
    );

    exu_decode_pipe #(.XLEN(32), .PC_SIZE(32), .DEPTH(DEPTH), .ENABLE_M(0)) dut_n (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(n_i_ready),
        .i_instr(i_instr), .i_pc(i_pc), .i_prdt_taken(i_prdt_taken), .flush(flush),
        .o_valid(n_valid), .o_ready(o_ready),
        .o_rs1en(n_rs1en), .o_rs2en(n_rs2en), .o_rdwen(n_rdwen),
        .o_rs1idx(n_rs1idx), .o_rs2idx(n_rs2idx), .o_rdidx(n_rdidx),
        .o_imm(n_imm), .o_pc(n_pc), .o_prdt_taken(n_prdt), .o_grp(n_grp),
        .o_bjp(n_bjp), .o_jal(n_jal), .o_jalr(n_jalr), .o_bxx(n_bxx),
        .o_illegal(n_illegal), .o_count(n_count)
    );

    obs_t obs_m, obs_n;
    always_comb begin
        obs_m = '0;
        obs_m.valid = m_valid;  obs_m.count = m_count;
        obs_m.rs1en = m_rs1en;  obs_m.rs2en = m_rs2en;  obs_m.rdwen = m_rdwen;
        obs_m.rs1idx = m_rs1idx; obs_m.rs2idx = m_rs2idx; obs_m.rdidx = m_rdidx;
        obs_m.imm = m_imm;  obs_m.pc = m_pc;  obs_m.prdt = m_prdt;  obs_m.grp = m_grp;
        obs_m.bjp = m_bjp;  obs_m.jal = m_jal;  obs_m.jalr = m_jalr;  obs_m.bxx = m_bxx;
        obs_m.illegal = m_illegal;
        obs_n = '0;
        obs_n.valid = n_valid;  obs_n.count = n_count;
        obs_n.rs1en = n_rs1en;  obs_n.rs2en = n_rs2en;  obs_n.rdwen = n_rdwen;
        obs_n.rs1idx = n_rs1idx; obs_n.rs2idx = n_rs2idx; obs_n.rdidx = n_rdidx;
        obs_n.imm = n_imm;  obs_n.pc = n_pc;  obs_n.prdt = n_prdt;  obs_n.grp = n_grp;
        obs_n.bjp = n_bjp;  obs_n.jal = n_jal;  obs_n.jalr = n_jalr;  obs_n.bxx = n_bxx;
        obs_n.illegal = n_illegal;
    end

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference decoder: immediates rebuilt arithmetically from the ISA bit map
    function automatic obs_t ref_decode(logic [31:0] w, logic [31:0] pc, logic prdt, bit m);
        obs_t d = '0;
        bit ok = 1'b0;
        int op = int'(w[6:0]);
        int f3 = int'(w[14:12]);
        int f7 = int'(w[31:25]);
        int imm_i = int'(w[31:20]) - (w[31] ? 4096 : 0);
        int imm_s = int'(w[31:25]) * 32 + int'(w[11:7]) - (w[31] ? 4096 : 0);
        int imm_b = int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2
                    - (w[31] ? 4096 : 0);
        int imm_j = int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2
                    - (w[31] ? (1 << 20) : 0);
        d.rs1idx = w[19:15];
        d.rs2idx = w[24:20];
        d.rdidx  = w[11:7];
        case (op)
            'h37, 'h17: begin ok = 1; d.rdwen = 1; d.imm = w & 32'hFFFF_F000; end
            'h6F: begin ok = 1; d.grp = 1; d.jal = 1; d.rdwen = 1; d.imm = imm_j; end
            'h67: begin ok = (f3 == 0); d.grp = 1; d.jalr = 1; d.rs1en = 1; d.rdwen = 1; d.imm = imm_i; end
            'h63: begin ok = (f3 != 2 && f3 != 3); d.grp = 1; d.bxx = 1; d.rs1en = 1; d.rs2en = 1; d.imm = imm_b; end
            'h03: begin ok = (f3 <= 2 || f3 == 4 || f3 == 5); d.grp = 2; d.rs1en = 1; d.rdwen = 1; d.imm = imm_i; end
            'h23: begin ok = (f3 <= 2); d.grp = 2; d.rs1en = 1; d.rs2en = 1; d.imm = imm_s; end
            'h13: begin
                ok = (f3 == 1) ? (f7 == 0) : (f3 == 5) ? (f7 == 0 || f7 == 32) : 1'b1;
                d.rs1en = 1; d.rdwen = 1; d.imm = imm_i;
            end
            'h33: begin
                ok = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5)) || (f7 == 1 && m);
                if (f7 == 1) d.grp = 3;
                d.rs1en = 1; d.rs2en = 1; d.rdwen = 1;
            end
            default: ok = 0;
        endcase
        if (!ok) begin
            d.rs1en = 0; d.rs2en = 0; d.rdwen = 0; d.imm = 0; d.grp = 7;
            d.jal = 0; d.jalr = 0; d.bxx = 0; d.illegal = 1;
        end else if (w[11:7] == 5'd0) begin
            d.rdwen = 0;
        end
        d.bjp  = d.jal | d.jalr | d.bxx;
        d.pc   = pc;
        d.prdt = prdt;
        return d;
    endfunction

    ent_t mq[$];
    obs_t exp_m = '0;
    obs_t exp_n = '0;

    task automatic cmp(string who, obs_t o, obs_t e);
        check({who, ".valid"}, o.valid, e.valid);
        check({who, ".count"}, o.count, e.count);
        check({who, ".rs1en"}, o.rs1en, e.rs1en);
        check({who, ".rs2en"}, o.rs2en, e.rs2en);
        check({who, ".rdwen"}, o.rdwen, e.rdwen);
        check({who, ".rs1idx"}, o.rs1idx, e.rs1idx);
        check({who, ".rs2idx"}, o.rs2idx, e.rs2idx);
        check({who, ".rdidx"}, o.rdidx, e.rdidx);
        check({who, ".imm"}, o.imm, e.imm);
        check({who, ".pc"}, o.pc, e.pc);
        check({who, ".prdt"}, o.prdt, e.prdt);
        check({who, ".grp"}, o.grp, e.grp);
        check({who, ".bjp"}, o.bjp, e.bjp);
        check({who, ".jal"}, o.jal, e.jal);
        check({who, ".jalr"}, o.jalr, e.jalr);
        check({who, ".bxx"}, o.bxx, e.bxx);
        check({who, ".illegal"}, o.illegal, e.illegal);
    endtask

    // One clock: drive, check i_ready, advance model on the edge, check outputs
    task automatic step(bit r, bit f, bit iv, bit ordy, logic [31:0] ins,
                        logic [31:0] pc, bit pt);
        bit   ir;
        ent_t e;
        rst = r; flush = f; i_valid = iv; o_ready = ordy;
        i_instr = ins; i_pc = pc; i_prdt_taken = pt;
        #1;
        ir = !r && !f && (mq.size() < DEPTH);
        check("m.i_ready", m_i_ready, ir);
        check("n.i_ready", n_i_ready, ir);
        @(posedge clk);
        if (r) begin
            mq.delete();
            exp_m = '0;
            exp_n = '0;
        end else if (f) begin
            mq.delete();
            exp_m.valid = 0;
            exp_n.valid = 0;
        end else begin
            if (mq.size() > 0 && (!exp_m.valid || ordy)) begin
                e = mq.pop_front();
                exp_m = ref_decode(e.instr, e.pc, e.prdt, 1'b1);
                exp_n = ref_decode(e.instr, e.pc, e.prdt, 1'b0);
                exp_m.valid = 1;
                exp_n.valid = 1;
            end else if (ordy) begin
                exp_m.valid = 0;
                exp_n.valid = 0;
            end
            if (iv && ir) begin
                e.instr = ins; e.pc = pc; e.prdt = pt;
                mq.push_back(e);
            end
        end
        exp_m.count = 3'(mq.size());
        exp_n.count = 3'(mq.size());
        #1;
        cmp("m", obs_m, exp_m);
        cmp("n", obs_n, exp_n);
    endtask

    task automatic idle(bit ordy, int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, ordy, 32'h0000_0013, 32'h0, 0);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [9];
        logic [31:0] w = $urandom;
        int k = $urandom_range(0, 10);
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
        if (k == 0) return w;
        if (k == 1) return 32'h0000_0013;
        w[6:0] = ops[k - 2];
        case ($urandom_range(0, 3))
            0: w[31:25] = 7'h00;
            1: w[31:25] = 7'h20;
            2: w[31:25] = 7'h01;
            default: ;
        endcase
        return w;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] burst [6];
        burst = '{32'h0010_0093, 32'h4020_81B3, 32'h0041_2283,
                  32'h0051_2423, 32'h0100_00EF, 32'h4033_D313};
        rst = 1; flush = 0; i_valid = 0; o_ready = 0;
        i_instr = 0; i_pc = 0; i_prdt_taken = 0;
        @(posedge clk);
        #1;

        // Reset state
        step(1, 0, 0, 0, 32'h0, 32'h0, 0);
        step(1, 0, 1, 1, 32'h0, 32'h0, 0);
        check("rst.grp", m_grp, 3'd0);

        // Single BEQ: valid two edges after the push
        step(0, 0, 1, 1, 32'h0832_00E3, 32'd128, 1);
        check("t1.valid_early", m_valid, 1'b0);
        idle(1, 1);
        check("t1.valid", m_valid, 1'b1);
        check("t1.rs1idx", m_rs1idx, 5'd4);
        check("t1.rs2idx", m_rs2idx, 5'd3);
        check("t1.imm", m_imm, 32'h0000_0880);
        check("t1.bxx", m_bxx, 1'b1);
        check("t1.bjp", m_bjp, 1'b1);
        check("t1.rdwen", m_rdwen, 1'b0);
        check("t1.pc", m_pc, 32'd128);
        idle(1, 2);

        // Back-to-back BEQ then LUI, one per cycle
        step(0, 0, 1, 1, 32'h8000_0FE3, 32'd256, 0);
        step(0, 0, 1, 1, 32'h8000_17B7, 32'd260, 0);
        check("t2.beq_imm", m_imm, 32'hFFFF_F81E);
        idle(1, 1);
        check("t2.lui_imm", m_imm, 32'h8000_1000);
        check("t2.lui_rd", m_rdidx, 5'd15);
        check("t2.lui_rdwen", m_rdwen, 1'b1);
        check("t2.lui_grp", m_grp, 3'd0);
        idle(1, 2);

        // Capacity DEPTH+1 with o_ready held low, then drain in order
        for (int i = 0; i < 6; i++) step(0, 0, 1, 0, burst[i], 32'h1000 + 32'(4 * i), i[0]);
        check("t3.count_full", m_count, 3'd4);
        check("t3.i_ready_full", m_i_ready, 1'b0);
        idle(0, 2);
        idle(1, 7);

        // Flush with queue 3 deep and output held; flush-cycle push dropped
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, burst[i], 32'h2000 + 32'(4 * i), 0);
        step(0, 1, 1, 0, 32'h0000_0113, 32'h2FF0, 1);
        check("t4.valid", m_valid, 1'b0);
        check("t4.count", m_count, 3'd0);
        idle(1, 3);

        // MUL with and without the M extension
        step(0, 0, 1, 1, 32'h0231_00B3, 32'h3000, 0);
        idle(1, 1);
        check("t5.n_illegal", n_illegal, 1'b1);
        check("t5.n_grp", n_grp, 3'd7);
        check("t5.n_rs1en", n_rs1en, 1'b0);
        check("t5.m_grp", m_grp, 3'd3);
        check("t5.m_rdwen", m_rdwen, 1'b1);
        idle(1, 2);

        // Reset mid-operation, then resume
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, burst[i + 2], 32'h4000 + 32'(4 * i), 0);
        check("t6.pre_count", m_count, 3'd2);
        step(1, 0, 1, 0, 32'h0000_0113, 32'h4100, 0);
        check("t6.valid", m_valid, 1'b0);
        check("t6.count", m_count, 3'd0);
        step(1, 0, 1, 1, 32'h0000_0113, 32'h4104, 0);
        step(0, 0, 1, 1, 32'h0000_0113, 32'h4108, 1);
        idle(1, 3);

        // Random traffic against the model
        for (int i = 0; i < 800; i++)
            step($urandom_range(0, 99) == 0, $urandom_range(0, 39) == 0,
                 $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
                 rand_instr(), $urandom & 32'hFFFF_FFFC, 1'($urandom));
        idle(1, 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
